// File: rtl/alu_sll_if.sv
// alu_sll_if: operand/result bundle for the SLL function unit.
//   master : drives in_valid, rs1, rs2; receives rd, out_valid
//   slave  : the shifter side (receives operands, returns result)
interface alu_sll_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] rd;
  logic            out_valid;

  modport master (output in_valid, rs1, rs2, input  rd, out_valid);
  modport slave  (input  in_valid, rs1, rs2, output rd, out_valid);
endinterface

// File: rtl/alu_sll.sv
// alu_sll: registered 32-bit logical left shift, rd = rs1 << rs2[4:0].
// Built as a 5-level log barrel shifter (1, 2, 4, 8, 16), one 2:1 mux per
// bit per level, followed by an output register.
//
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset (clears rd and out_valid)
//   bus   alu_sll_if.slave: in_valid/rs1/rs2 in, rd/out_valid out
//
// Build option: define ALU_SLL_PIPE_EN to add a register after the 4-bit
// level, giving 2-cycle latency at full throughput. Default is 1 cycle.

// One barrel level: shift by SH when en_i, otherwise pass through.
module alu_sll_lvl #(
  parameter int XLEN = 32,
  parameter int SH   = 1
) (
  input  logic [XLEN-1:0] d_i,
  input  logic            en_i,
  output logic [XLEN-1:0] q_o
);
  assign q_o = en_i ? {d_i[XLEN-1-SH:0], {SH{1'b0}}} : d_i;
endmodule

module alu_sll #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_sll_if.slave bus
);
`ifdef ALU_SLL_PIPE_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif
  // Index of the first level fed from the optional mid-pipe register.
  localparam int CUT = 3;

  logic [SHAMT_W-1:0][XLEN-1:0] lvl_in;
  logic [SHAMT_W-1:0][XLEN-1:0] lvl_out;
  logic [SHAMT_W-1:0]           en;
  logic [STAGES-1:0]            vld_pipe_q;
  logic [XLEN-1:0]              rd_q;
  logic                         out_en;

  // Upper rs2 bits are architecturally ignored.
  logic unused_rs2;
  assign unused_rs2 = ^bus.rs2[XLEN-1:SHAMT_W];

  assign lvl_in[0]     = bus.rs1;
  assign en[CUT-1:0]   = bus.rs2[CUT-1:0];

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    alu_sll_lvl #(.XLEN(XLEN), .SH(1 << k)) u_lvl (
      .d_i  (lvl_in[k]),
      .en_i (en[k]),
      .q_o  (lvl_out[k])
    );
    if (k > 0 && k != CUT) begin : g_chain
      assign lvl_in[k] = lvl_out[k-1];
    end
  end

`ifdef ALU_SLL_PIPE_EN
  // Mid-pipe register: partial result plus the shamt bits still needed.
  logic [XLEN-1:0]        mid_q;
  logic [SHAMT_W-1:CUT]   shhi_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_q  <= '0;
      shhi_q <= '0;
    end else if (bus.in_valid) begin
      mid_q  <= lvl_out[CUT-1];
      shhi_q <= bus.rs2[SHAMT_W-1:CUT];
    end
  end

  assign lvl_in[CUT]         = mid_q;
  assign en[SHAMT_W-1:CUT]   = shhi_q;
  assign out_en              = vld_pipe_q[0];
`else
  assign lvl_in[CUT]         = lvl_out[CUT-1];
  assign en[SHAMT_W-1:CUT]   = bus.rs2[SHAMT_W-1:CUT];
  assign out_en              = bus.in_valid;
`endif

  // vld_pipe_q[s] marks valid data at the output of register stage s.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
    end else begin
      for (int s = STAGES - 1; s > 0; s--) vld_pipe_q[s] <= vld_pipe_q[s-1];
      vld_pipe_q[0] <= bus.in_valid;
    end
  end

  // rd holds its last value while idle.
  always_ff @(posedge clk) begin
    if (!rst_n)      rd_q <= '0;
    else if (out_en) rd_q <= lvl_out[SHAMT_W-1];
  end

  assign bus.rd        = rd_q;
  assign bus.out_valid = vld_pipe_q[STAGES-1];
endmodule

// File: tb/tb_alu_sll.sv
module tb_alu_sll;
`ifdef ALU_SLL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  bit   chk_en;

  alu_sll_if #(.XLEN(32)) bus ();

  alu_sll #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: each accepted pair yields rs1 * 2^(rs2 mod 32) mod 2^32,
  // delivered LAT edges later; reset flushes everything in flight.
  typedef struct { bit v; logic [31:0] d; } ent_t;
  ent_t        pend[$];
  logic [31:0] exp_rd;
  bit          exp_ov;

  always @(posedge clk) begin
    ent_t e;
    if (!rst_n) begin
      pend.delete();
      for (int i = 0; i < LAT - 1; i++) pend.push_back('{v: 1'b0, d: '0});
      exp_rd = '0;
      exp_ov = 1'b0;
    end else begin
      e.v = bus.in_valid;
      e.d = 32'((64'(bus.rs1) * (64'd1 << (bus.rs2 % 32))) & 64'hFFFF_FFFF);
      pend.push_back(e);
      e = pend.pop_front();
      exp_ov = e.v;
      if (e.v) exp_rd = e.d;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd", bus.rd, exp_rd);
      check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
    end
  end

  // Apply one pair, go idle, then check the result literal once it is due.
  task automatic shot(input string nm, input logic [32:0] a, input logic [31:0] b,
                      input logic [31:0] exp);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.rs1      = a[31:0];
    bus.rs2      = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check(nm, bus.rd, exp);
    check({nm, "_vld"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  logic [31:0] s_exp [5];
  logic [31:0] s_got [5];
  int          n_ov;

  initial begin
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.rs1 = 32'hFFFF_FFFF;
    bus.rs2 = 32'd0;

    // Reset overrides in_valid
    @(posedge clk); chk_en = 1'b1;
    @(negedge clk);
    check("rst_rd_0", bus.rd, 32'd0);
    check("rst_vld_0", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    check("rst_rd_1", bus.rd, 32'd0);
    check("rst_vld_1", {31'd0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_rd", bus.rd, 32'd0);
    check("idle_vld", {31'd0, bus.out_valid}, 32'd0);

    shot("sll_1",      33'h0_5555_5555, 32'd1,          32'hAAAA_AAAA);
    shot("sll_10",     33'h0_5555_5555, 32'd10,         32'h5555_5400);
    shot("mask_72",    33'h0_5555_5555, 32'd72,         32'h5555_5500);
    shot("ones_3",     33'h0_FFFF_FFFF, 32'd3,          32'hFFFF_FFF8);
    shot("trunc_33b",  33'h1_0000_0000, 32'd1,          32'h0000_0000);
    shot("shamt_0",    33'h0_8000_0001, 32'd0,          32'h8000_0001);
    shot("shamt_31",   33'h0_8000_0001, 32'd31,         32'h8000_0000);
    shot("hi_rs2",     33'h0_8000_0001, 32'hFFFF_FFE0,  32'h8000_0001);
    shot("mix_13",     33'h0_1234_5678, 32'd13,         32'h8ACF_0000);

    // Idle after a result: rd holds, out_valid drops
    @(negedge clk);
    check("hold_rd", bus.rd, 32'h8ACF_0000);
    check("hold_vld", {31'd0, bus.out_valid}, 32'd0);

    // Streaming: pair i is rs1=i+1, rs2=i -> (i+1)<<i
    s_exp[0] = 32'd1; s_exp[1] = 32'd4; s_exp[2] = 32'd12; s_exp[3] = 32'd32; s_exp[4] = 32'd80;
    n_ov = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (n_ov < 5) s_got[n_ov] = bus.rd;
        n_ov++;
      end
      bus.in_valid = (c < 5);
      bus.rs1      = 32'(c + 1);
      bus.rs2      = 32'(c);
    end
    check("stream_count", 32'(n_ov), 32'd5);
    for (int i = 0; i < 5; i++) check($sformatf("stream_%0d", i), s_got[i], s_exp[i]);
    check("stream_hold", bus.rd, 32'd80);

    // Reset while a result is in flight discards it
    @(negedge clk);
    bus.in_valid = 1'b1; bus.rs1 = 32'h0000_00F0; bus.rs2 = 32'd4;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    check("flush_rd", bus.rd, 32'd0);
    check("flush_vld", {31'd0, bus.out_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("flush_idle_rd", bus.rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_sll.md
Name: alu_sll

Overview:
Registered 32-bit logical-left-shift unit for the integer ALU; computes rd = rs1 << rs2[4:0] (RV32I SLL/SLLI semantics).
- Built as an explicit 5-level logarithmic barrel shifter (stages of 1, 2, 4, 8, 16 bits), each level a 2:1 mux per bit.
- Result is captured in an output register.
- Sits in the execute stage beside the other alu_* function units.

Parameters:
- XLEN, 32, operand/result width; only 32 is required to be supported.
- SHAMT_W, 5, number of low rs2 bits used as shift amount; must equal log2(XLEN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  operands on rs1/rs2 are valid this cycle.
- rs1  input  32  value to be shifted.
- rs2  input  32  shift source; only rs2[4:0] used, rs2[31:5] ignored.
- rd  output  32  registered shift result.
- out_valid  output  1  rd holds a result produced from an accepted operand pair.

Behaviour:
- Reset: on a rising clk with rst_n=0, rd<=0 and out_valid<=0. Reset overrides in_valid in the same cycle, and any in-flight result is discarded.
- Shift amount: shamt = rs2[4:0]. Upper rs2 bits have no effect, e.g. rs2=72 behaves as shamt=8.
- Shift semantics: rd = (rs1 << shamt) truncated to 32 bits. Vacated LSBs are filled with 0; bits shifted past bit 31 are lost.
- shamt=0 passes rs1 through unchanged; shamt=31 leaves only rs1[0] in rd[31].
- Datapath: level k (k=0..4) shifts by 2^k when shamt[k]=1, otherwise passes through. Levels are purely combinational, in order 1, 2, 4, 8, 16.
- Latency (default build): 1 cycle. Operands applied before rising edge N appear on rd after edge N.
- Accept: when in_valid=1 at a rising edge (rst_n=1), rd <= shift result and out_valid <= 1.
- Idle: when in_valid=0 at a rising edge, rd holds its previous value and out_valid <= 0.
- Back-to-back: a new operand pair may be accepted every cycle; there is no stall and no backpressure.
- Sampling rule: rd is stable from just after the rising edge until the next one, so sampling on the falling edge always sees the result of the last accepted pair.
- No X propagation from unused rs2 bits.

Optional Feature:
- Macro ALU_SLL_PIPE_EN.
- When defined: an additional pipeline register is placed after the 4-bit level (between levels 2 and 3). Latency becomes 2 cycles.
  - out_valid follows in_valid delayed by 2 cycles.
  - Throughput stays 1 per cycle.
  - Reset clears both stages and their valid bits.
- When undefined: single output register with 1-cycle latency, as described above.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with in_valid=1, rs1=0xFFFFFFFF -> rd=0 and out_valid=0 throughout; release, then idle -> rd remains 0.
- Basic shifts: rs1=1431655765 (0x55555555) with rs2=1 -> rd=2863311530 (0xAAAAAAAA); same rs1 with rs2=10 -> rd=1431655424 (0x55555400), each 1 cycle after acceptance.
- Shift-amount masking: rs1=1431655765, rs2=72 -> rd=1431655680 (0x55555500), i.e. shamt=8.
- All-ones and overflow truncation: rs1=4294967295, rs2=3 -> rd=4294967288 (0xFFFFFFF8); rs1 driven with 33-bit 4294967296 (truncated to 0), rs2=1 -> rd=0.
- Boundaries: rs1=0x80000001 with shamt=0 -> 0x80000001; shamt=31 -> 0x80000000; rs2=0xFFFFFFE0 -> unchanged rs1.
- Streaming and valid: 5 consecutive accepted pairs, then in_valid=0 -> out_valid high for exactly 5 cycles with results in order, rd holds the last value afterward. With ALU_SLL_PIPE_EN, the same sequence appears delayed by one extra cycle.
